dcache_tag_ctrl: RTL and testbench

Initiator side of the 256-entry x 19-bit dual-port tag RAM (8-bit raddr/waddr, r_en/w_en, 19-bit din/dout, 1-cycle read latency).
- Accepts CPU lookup requests and drives the RAM read port.
- Compares the returned entry to decide hit or miss.
- On a miss, issues a block refill request and writes the new tag back.
- Clears the array after reset and on flush.

---
 rtl/dcache_tag_ctrl_pkg.sv | 22 ++
 rtl/dcache_tag_ctrl_sweeper.sv | 26 ++
 rtl/dcache_tag_ctrl.sv | 158 +++++++++++++++
 tb/tb_dcache_tag_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_tag_ctrl_pkg.sv
// Shared types and sizes for the data-cache tag controller.
package dcache_tag_ctrl_pkg;

   localparam int CACHE_INDEX_W  = 8;
   localparam int CACHE_OFFSET_W = 6;
   localparam int CACHE_TAG_W    = 18;

   // One tag RAM word: valid flag on top, stored tag below.
   typedef struct packed {
      logic                   valid;
      logic [CACHE_TAG_W-1:0] tag;
   } tag_entry_t;

   typedef enum logic [2:0] {
      INIT,
      RUN,
      MISS_REQ,
      MISS_WAIT,
      FILL_WR
   } tag_ctrl_state_t;

endpackage

// File: rtl/dcache_tag_ctrl_sweeper.sv
// Index counter that walks every tag RAM entry while the array is being cleared.
module tag_init_sweeper #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             advance,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   // Counter restarts at 0 on clear and steps once per sweep cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (advance) begin
         count <= count + 1'b1;
      end
   end

   assign done = (count == {CNT_W{1'b1}});

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Tag lookup controller: pipelined hit check, miss refill handshake and array clearing.
module dcache_tag_ctrl
   import dcache_tag_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int INDEX_W  = CACHE_INDEX_W,
   parameter int OFFSET_W = CACHE_OFFSET_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            req_valid,
   input  logic [ADDR_W-1:0]               req_addr,
   output logic                            req_ready,
   output logic                            resp_valid,
   output logic                            resp_hit,
   output logic                            miss_valid,
   output logic [ADDR_W-1:0]               miss_addr,
   input  logic                            miss_ready,
   input  logic                            fill_done,
   input  logic                            flush,
   output logic                            busy,
   output logic [INDEX_W-1:0]              tag_raddr,
   output logic                            tag_r_en,
   output logic [INDEX_W-1:0]              tag_waddr,
   output logic                            tag_w_en,
   output logic [ADDR_W-INDEX_W-OFFSET_W:0] tag_din,
   input  logic [ADDR_W-INDEX_W-OFFSET_W:0] tag_dout
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

   tag_ctrl_state_t    state, state_next;
   logic               s1_valid;
   logic [TAG_W-1:0]   s1_tag;
   logic [INDEX_W-1:0] s1_index;
   logic               flush_pending, flush_pending_next;
   logic               accept, hit;
   logic               sweep_clear, sweep_done;
   logic [INDEX_W-1:0] sweep_count;
   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;
   tag_entry_t         rd_entry, fill_entry;
   logic               unused_offset_bits;

   assign req_index  = req_addr[OFFSET_W +: INDEX_W];
   assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
   assign rd_entry   = tag_dout;
   assign fill_entry = '{valid: 1'b1, tag: s1_tag};
   assign hit        = s1_valid && rd_entry.valid && (rd_entry.tag == s1_tag);

   // Byte offset within a block never affects tag lookup.
   assign unused_offset_bits = ^req_addr[OFFSET_W-1:0];

   tag_init_sweeper #(.CNT_W(INDEX_W)) u_sweeper (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (sweep_clear),
      .advance (state == INIT),
      .count   (sweep_count),
      .done    (sweep_done)
   );

   // State, flush request and the stage-1 lookup context.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= INIT;
         flush_pending <= 1'b0;
         s1_valid      <= 1'b0;
         s1_tag        <= '0;
         s1_index      <= '0;
      end else begin
         state         <= state_next;
         flush_pending <= flush_pending_next;
         if (accept) begin
            s1_valid <= 1'b1;
            s1_tag   <= req_tag;
            s1_index <= req_index;
         end else if (state == MISS_REQ || state == MISS_WAIT) begin
            s1_valid <= s1_valid;
         end else if (state == RUN && s1_valid && !hit) begin
            s1_valid <= 1'b1;
         end else begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Next-state and outputs; tag write enable is gated by rst_n so it stays low while reset is held.
   always_comb begin
      state_next         = state;
      flush_pending_next = flush_pending | flush;
      req_ready          = 1'b0;
      accept             = 1'b0;
      resp_valid         = 1'b0;
      resp_hit           = 1'b0;
      miss_valid         = 1'b0;
      miss_addr          = '0;
      tag_r_en           = 1'b0;
      tag_raddr          = '0;
      tag_w_en           = 1'b0;
      tag_waddr          = '0;
      tag_din            = '0;
      sweep_clear        = 1'b1;
      busy               = (state != RUN);
      case (state)
         INIT: begin
            tag_w_en           = rst_n;
            tag_waddr          = sweep_count;
            sweep_clear        = flush;
            flush_pending_next = 1'b0;
            if (!flush && sweep_done) begin
               state_next = RUN;
            end
         end
         RUN: begin
            req_ready = !flush_pending && !(s1_valid && !hit);
            accept    = req_valid && req_ready;
            tag_r_en  = accept;
            tag_raddr = accept ? req_index : '0;
            if (s1_valid && hit) begin
               resp_valid = 1'b1;
               resp_hit   = 1'b1;
            end
            if (s1_valid && !hit) begin
               state_next = MISS_REQ;
            end else if (flush_pending) begin
               state_next = INIT;
            end
         end
         MISS_REQ: begin
            miss_valid = 1'b1;
            miss_addr  = {s1_tag, s1_index, {OFFSET_W{1'b0}}};
            if (miss_ready) begin
               state_next = MISS_WAIT;
            end
         end
         MISS_WAIT: begin
            if (fill_done) begin
               state_next = FILL_WR;
            end
         end
         FILL_WR: begin
            tag_w_en   = 1'b1;
            tag_waddr  = s1_index;
            tag_din    = fill_entry;
            resp_valid = 1'b1;
            state_next = (flush_pending || flush) ? INIT : RUN;
         end
         default: begin
            state_next = INIT;
         end
      endcase
      if (state_next == INIT && state != INIT) begin
         flush_pending_next = 1'b0;
      end
   end

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Self-checking bench for dcache_tag_ctrl with a behavioural tag RAM and cache model.
module tb_dcache_tag_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        resp_valid;
   logic        resp_hit;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_ready;
   logic        fill_done;
   logic        flush;
   logic        busy;
   logic [7:0]  tag_raddr;
   logic        tag_r_en;
   logic [7:0]  tag_waddr;
   logic        tag_w_en;
   logic [18:0] tag_din;
   logic [18:0] tag_dout = '0;

   int checks   = 0;
   int failures = 0;

   logic [18:0] ram [256];
   bit          ref_valid [256];
   logic [17:0] ref_tag [256];

   always #5 clk = ~clk;

   dcache_tag_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_hit   (resp_hit),
      .miss_valid (miss_valid),
      .miss_addr  (miss_addr),
      .miss_ready (miss_ready),
      .fill_done  (fill_done),
      .flush      (flush),
      .busy       (busy),
      .tag_raddr  (tag_raddr),
      .tag_r_en   (tag_r_en),
      .tag_waddr  (tag_waddr),
      .tag_w_en   (tag_w_en),
      .tag_din    (tag_din),
      .tag_dout   (tag_dout)
   );

   // Dual-port tag RAM with one-cycle registered read.
   always @(posedge clk) begin
      if (tag_w_en) ram[tag_waddr] <= tag_din;
      if (tag_r_en) tag_dout <= ram[tag_raddr];
   end

   function automatic bit model_hit(input logic [31:0] a);
      return ref_valid[a[13:6]] && (ref_tag[a[13:6]] == a[31:14]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_sweep(input string name);
      for (int i = 0; i < 256; i++) begin
         #1;
         checks++;
         if (tag_w_en !== 1'b1 || tag_waddr !== i[7:0] || tag_din !== 19'h0 || busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_sweep step=%0d got w_en=%b waddr=%h din=%h busy=%b ready=%b expected 1 %h 0 1 0",
                     name, i, tag_w_en, tag_waddr, tag_din, busy, req_ready, i[7:0]);
         end
         tick();
      end
      #1;
      checks++;
      if (busy !== 1'b0 || req_ready !== 1'b1 || tag_w_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s_sweep_end got busy=%b ready=%b w_en=%b expected 0 1 0", name, busy, req_ready, tag_w_en);
      end
   endtask

   task automatic do_lookup(input logic [31:0] addr, input int mr_delay, input int fill_delay, input bit flush_in_wait);
      logic [7:0]  idx;
      logic [17:0] tg;
      logic [31:0] exp_ma;
      bit          exp_hit;
      idx     = addr[13:6];
      tg      = addr[31:14];
      exp_ma  = {tg, idx, 6'b0};
      exp_hit = model_hit(addr);
      req_valid = 1'b1;
      req_addr  = addr;
      #1;
      checks++;
      if (req_ready !== 1'b1 || tag_r_en !== 1'b1 || tag_raddr !== idx) begin
         failures++;
         $display("[TB] FAIL accept addr=%h got ready=%b r_en=%b raddr=%h expected 1 1 %h", addr, req_ready, tag_r_en, tag_raddr, idx);
      end
      tick();
      req_valid = 1'b0;
      req_addr  = $urandom;
      #1;
      checks++;
      if (resp_valid !== exp_hit || resp_hit !== exp_hit) begin
         failures++;
         $display("[TB] FAIL lookup_resp addr=%h got valid=%b hit=%b expected %b %b", addr, resp_valid, resp_hit, exp_hit, exp_hit);
      end
      if (exp_hit) begin
         tick();
      end else begin
         checks++;
         if (req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL miss_stall_ready got %b expected 0", req_ready);
         end
         tick();
         for (int d = 0; d < mr_delay; d++) begin
            miss_ready = 1'b0;
            fill_done  = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (miss_valid !== 1'b1 || miss_addr !== exp_ma || req_ready !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("[TB] FAIL miss_hold got valid=%b addr=%h ready=%b busy=%b expected 1 %h 0 1", miss_valid, miss_addr, req_ready, busy, exp_ma);
            end
            tick();
         end
         fill_done  = 1'b0;
         miss_ready = 1'b1;
         #1;
         checks++;
         if (miss_valid !== 1'b1 || miss_addr !== exp_ma) begin
            failures++;
            $display("[TB] FAIL miss_handshake got valid=%b addr=%h expected 1 %h", miss_valid, miss_addr, exp_ma);
         end
         tick();
         miss_ready = 1'b0;
         for (int w = 0; w < fill_delay; w++) begin
            flush = flush_in_wait && (w == 0);
            #1;
            checks++;
            if (miss_valid !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b1) begin
               failures++;
               $display("[TB] FAIL miss_wait got miss_valid=%b resp_valid=%b busy=%b expected 0 0 1", miss_valid, resp_valid, busy);
            end
            tick();
            flush = 1'b0;
         end
         fill_done = 1'b1;
         #1;
         tick();
         fill_done = 1'b0;
         #1;
         checks++;
         if (tag_w_en !== 1'b1 || tag_waddr !== idx || tag_din !== {1'b1, tg} || resp_valid !== 1'b1 || resp_hit !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_write got w_en=%b waddr=%h din=%h rv=%b rh=%b expected 1 %h %h 1 0",
                     tag_w_en, tag_waddr, tag_din, resp_valid, resp_hit, idx, {1'b1, tg});
         end
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
         tick();
         if (flush_in_wait) begin
            run_sweep("flush_after_miss");
            model_clear();
         end
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_addr   = '0;
      miss_ready = 1'b0;
      fill_done  = 1'b0;
      flush      = 1'b0;
      #12;
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || miss_valid !== 1'b0 ||
          miss_addr !== 32'h0 || tag_w_en !== 1'b0 || tag_r_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_values got busy=%b ready=%b rv=%b mv=%b ma=%h w_en=%b r_en=%b expected 1 0 0 0 0 0 0",
                  busy, req_ready, resp_valid, miss_valid, miss_addr, tag_w_en, tag_r_en);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_sweep("reset");
      model_clear();
   endtask

   task automatic test_cold_miss();
      do_lookup(32'h0001_2340, 1, 2, 1'b0);
   endtask

   task automatic test_hit();
      do_lookup(32'h0001_2340, 0, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      bit          exp [4];
      do_lookup(32'h0000_1000, 0, 0, 1'b0);
      do_lookup(32'h0040_2FC0, 2, 1, 1'b0);
      addrs[0] = 32'h0001_2340;
      addrs[1] = 32'h0000_1000;
      addrs[2] = 32'h0040_2FC0;
      addrs[3] = 32'h0001_237F;
      for (int i = 0; i < 4; i++) exp[i] = model_hit(addrs[i]);
      for (int i = 0; i < 5; i++) begin
         req_valid = (i < 4);
         req_addr  = (i < 4) ? addrs[i] : 32'h0;
         #1;
         if (i < 4) begin
            checks++;
            if (req_ready !== 1'b1) begin
               failures++;
               $display("[TB] FAIL b2b_ready slot=%0d got %b expected 1", i, req_ready);
            end
         end
         if (i > 0) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_hit !== exp[i-1]) begin
               failures++;
               $display("[TB] FAIL b2b_resp slot=%0d got valid=%b hit=%b expected 1 %b", i - 1, resp_valid, resp_hit, exp[i-1]);
            end
         end
         tick();
      end
      req_valid = 1'b0;
   endtask

   task automatic test_conflict();
      do_lookup(32'h0005_2340, 3, 1, 1'b0);
      do_lookup(32'h0001_2340, 0, 1, 1'b0);
      do_lookup(32'h0005_2340, 1, 0, 1'b0);
   endtask

   task automatic test_flush();
      do_lookup(32'h0005_2340, 0, 0, 1'b0);
      flush = 1'b1;
      #1;
      tick();
      flush = 1'b0;
      #1;
      checks++;
      if (req_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flush_block got ready=%b busy=%b expected 0 0", req_ready, busy);
      end
      tick();
      run_sweep("flush");
      model_clear();
      do_lookup(32'h0005_2340, 0, 1, 1'b0);
   endtask

   task automatic test_flush_during_miss();
      do_lookup(32'h0123_4580, 1, 2, 1'b1);
      do_lookup(32'h0123_4580, 0, 0, 1'b0);
   endtask

   task automatic test_reset_mid_miss();
      req_valid = 1'b1;
      req_addr  = 32'hDEAD_BEC0;
      #1;
      tick();
      req_valid = 1'b0;
      #1;
      tick();
      miss_ready = 1'b1;
      #1;
      checks++;
      if (miss_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midreset_miss_req got miss_valid=%b expected 1", miss_valid);
      end
      tick();
      miss_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (miss_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1 || tag_w_en !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_outputs got mv=%b rv=%b ready=%b busy=%b w_en=%b expected 0 0 0 1 0",
                  miss_valid, resp_valid, req_ready, busy, tag_w_en);
      end
      fill_done = 1'b1;
      tick();
      fill_done = 1'b0;
      tick();
      rst_n = 1'b1;
      run_sweep("midreset");
      model_clear();
      do_lookup(32'hDEAD_BEC0, 0, 0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      logic [7:0]  idx_sel [3];
      idx_sel[0] = 8'h10;
      idx_sel[1] = 8'h11;
      idx_sel[2] = 8'h8D;
      for (int i = 0; i < 6; i++) begin
         pool[i] = {18'($urandom_range(0, 3)), idx_sel[$urandom_range(0, 2)], 6'($urandom_range(0, 63))};
      end
      for (int n = 0; n < 40; n++) begin
         do_lookup(pool[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end
   endtask

   // Hard stop if the sequence ever stalls.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence.
   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_back_to_back();
      test_conflict();
      test_flush();
      test_flush_during_miss();
      test_reset_mid_miss();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
